// File: rtl/video_dbl_pkg.sv
// video_dbl_pkg: shared types and defaults for the VGA scan doubler.
//   LINE_PIX_DEF / AW_DEF / HS_PIX_DEF : default line length, buffer address
//                                        width and hsync width
//   buf_word_t                         : one line-buffer word {blank, pix}
//   pass_st_t                          : replay pass state
package video_dbl_pkg;

   localparam int LINE_PIX_DEF = 448;
   localparam int AW_DEF       = 9;
   localparam int HS_PIX_DEF   = 52;

   typedef struct packed {
      logic       blank;
      logic [7:0] pix;
   } buf_word_t;

   // IDLE: nothing to show, PASS0/PASS1: replaying, HOLD: both passes done
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS0 = 2'd1,
      ST_PASS1 = 2'd2,
      ST_HOLD  = 2'd3
   } pass_st_t;

endpackage

// File: rtl/video_dbl_lbuf.sv
// video_dbl_lbuf: ping-pong line buffer, simple dual-port RAM of
// 2**(AW+1) words. The bank bit is the address MSB.
//   clk     : clock
//   we_i    : write enable, waddr_i / wdata_i : write address / word
//   re_i    : read enable, raddr_i : read address
//   rdata_o : registered read word (one clk after re_i)
module video_dbl_lbuf
   import video_dbl_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = $bits(buf_word_t)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW:0]   waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW:0]   raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**(AW+1)];

   // Reader and writer are always in different banks, so no
   // read-during-write behaviour needs defining.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/video_scandbl.sv
// video_scandbl: VGA scan doubler. Captures one TV line per bank of a
// ping-pong buffer and replays the previous line twice at the f0 rate.
//   clk, rst        : clock, synchronous active-high reset
//   c3, f0          : TV / VGA pixel strobes
//   tv_line_start   : TV line start (coincides with c3)
//   tv_blank, vplex_in : captured blank flag and pixel byte
//   vgaplex, vga_blank : replayed pixel / blank (blank forced when idle)
//   vga_line        : 0 on first replay pass, 1 on second
//   vga_hs          : hsync, first HS_PIX f0 ticks of each pass
//   plex_sel        : hires nibble select
module video_scandbl
   import video_dbl_pkg::*;
#(
   parameter int LINE_PIX = LINE_PIX_DEF,
   parameter int AW       = AW_DEF,
   parameter int HS_PIX   = HS_PIX_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       c3,
   input  logic       f0,
   input  logic       tv_line_start,
   input  logic       tv_blank,
   input  logic [7:0] vplex_in,
   output logic [7:0] vgaplex,
   output logic       vga_blank,
   output logic       vga_line,
   output logic       vga_hs,
   output logic       plex_sel
);

   localparam logic [AW-1:0] LAST   = AW'(LINE_PIX - 1);
   localparam logic [AW:0]   HS_LIM = (AW+1)'(HS_PIX);

   pass_st_t      st_q, st_d;
   logic          wbuf_q, wbuf_d, rbuf_q, rbuf_d, seen_q, seen_d;
   logic [AW-1:0] waddr_q, waddr_d, raddr_q, raddr_d, wr_addr;
   logic          show, rd_line, rd_hs;
   logic          rd_vld_q, show_q, line_q, hs_q;
   logic [7:0]    pix_q;
   logic          blank_q, oline_q, ohs_q, sel_q;
   buf_word_t     rd_word;

   video_dbl_lbuf #(.AW(AW)) u_lbuf (
      .clk     (clk),
      .we_i    (c3 & ~rst),
      .waddr_i ({wbuf_d, wr_addr}),
      .wdata_i ({tv_blank, vplex_in}),
      .re_i    (f0),
      .raddr_i ({rbuf_q, raddr_q}),
      .rdata_o (rd_word)
   );

   // Write side. The line-start byte lands in slot 0 of the new bank and
   // the counter moves past it, so the next byte takes slot 1.
   always_comb begin
      wbuf_d  = tv_line_start ? ~wbuf_q : wbuf_q;
      wr_addr = tv_line_start ? '0 : waddr_q;
      waddr_d = waddr_q;
      if (c3)
         waddr_d = (wr_addr < LAST) ? wr_addr + AW'(1) : wr_addr;
      else if (tv_line_start)
         waddr_d = '0;
   end

   // Read side: bank swap, read address and pass FSM.
   always_comb begin
      st_d    = st_q;
      raddr_d = raddr_q;
      rbuf_d  = rbuf_q;
      seen_d  = seen_q;
      if (tv_line_start) begin
         // The first start after reset only closes a partial line.
         seen_d  = 1'b1;
         rbuf_d  = wbuf_q;
         raddr_d = '0;
         st_d    = seen_q ? ST_PASS0 : ST_IDLE;
      end else if (f0 && (st_q == ST_PASS0 || st_q == ST_PASS1)) begin
         if (raddr_q < LAST) begin
            raddr_d = raddr_q + AW'(1);
         end else if (st_q == ST_PASS0) begin
            raddr_d = '0;
            st_d    = ST_PASS1;
         end else begin
            st_d = ST_HOLD;
         end
      end
      show    = (st_q == ST_PASS0) || (st_q == ST_PASS1);
      rd_line = (st_q == ST_PASS1) || (st_q == ST_HOLD);
      rd_hs   = show && ({1'b0, raddr_q} < HS_LIM);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= ST_IDLE;
         wbuf_q   <= 1'b0;
         rbuf_q   <= 1'b1;
         seen_q   <= 1'b0;
         waddr_q  <= '0;
         raddr_q  <= '0;
         rd_vld_q <= 1'b0;
         show_q   <= 1'b0;
         line_q   <= 1'b0;
         hs_q     <= 1'b0;
         pix_q    <= '0;
         blank_q  <= 1'b1;
         oline_q  <= 1'b0;
         ohs_q    <= 1'b0;
         sel_q    <= 1'b0;
      end else begin
         st_q     <= st_d;
         wbuf_q   <= wbuf_d;
         rbuf_q   <= rbuf_d;
         seen_q   <= seen_d;
         waddr_q  <= waddr_d;
         raddr_q  <= raddr_d;
         rd_vld_q <= f0;
         // Sideband travels with the RAM read so it lines up with the data.
         if (f0) begin
            show_q <= show;
            line_q <= rd_line;
            hs_q   <= rd_hs;
         end
         if (rd_vld_q) begin
            pix_q   <= show_q ? rd_word.pix : 8'h00;
            blank_q <= show_q ? rd_word.blank : 1'b1;
            oline_q <= line_q;
            ohs_q   <= hs_q;
         end
         sel_q <= f0 ? 1'b0 : ~sel_q;
      end
   end

   assign vgaplex   = pix_q;
   assign vga_blank = blank_q;
   assign vga_line  = oline_q;
   assign vga_hs    = ohs_q;
   assign plex_sel  = sel_q;

endmodule

// File: tb/tb_video_scandbl.sv
module tb_video_scandbl;

   localparam int LP = 448;
   localparam int HS = 52;

   logic       clk = 1'b0;
   logic       rst, c3, f0, tv_line_start, tv_blank;
   logic [7:0] vplex_in;
   logic [7:0] vgaplex;
   logic       vga_blank, vga_line, vga_hs, plex_sel;

   always #5 clk = ~clk;

   video_scandbl #(.LINE_PIX(LP), .AW(9), .HS_PIX(HS)) dut (
      .clk(clk), .rst(rst), .c3(c3), .f0(f0), .tv_line_start(tv_line_start),
      .tv_blank(tv_blank), .vplex_in(vplex_in), .vgaplex(vgaplex),
      .vga_blank(vga_blank), .vga_line(vga_line), .vga_hs(vga_hs),
      .plex_sel(plex_sel)
   );

   int checks = 0;
   int errors = 0;
   int gcyc   = 0;

   // Reference model: captured line, displayed line, f0 ticks since start.
   logic [8:0]  cap  [LP];
   logic [8:0]  disp [LP];
   int          wi = 0;
   int          k  = 0;
   bit          seen = 0, dvalid = 0, pend_due = 0;
   logic [10:0] exp_v = {8'h00, 3'b100};   // {pix, blank, line, hs}
   logic [10:0] pend  = '0;
   logic        exp_sel = 1'b0;
   logic [8:0]  last_wr;
   logic [8:0]  obs447;
   logic [11:0] rst_obs;
   int          hs_cnt, vis_cnt, exp_vis;

   // One clk: drive inputs, step the DUT, advance the model.
   task automatic cycle(input bit ls, input bit r, input logic [8:0] w);
      bit f0n, c3n;
      f0n = (gcyc % 2 == 0);
      c3n = (gcyc % 4 == 0);
      rst = r; c3 = c3n; f0 = f0n; tv_line_start = ls && c3n;
      tv_blank = w[8]; vplex_in = w[7:0];
      @(posedge clk); #1;
      if (r) begin
         exp_v = {8'h00, 3'b100}; exp_sel = 1'b0;
         pend_due = 0; seen = 0; dvalid = 0; wi = 0;
      end else begin
         if (pend_due) exp_v = pend;
         pend_due = 0;
         if (f0n) begin
            if (!dvalid)
               pend = {8'h00, 3'b100};
            else if (k < 2*LP) begin
               pend = {disp[k%LP][7:0], disp[k%LP][8], (k >= LP), ((k%LP) < HS)};
               k++;
            end else
               pend = {8'h00, 3'b110};
            pend_due = 1;
         end
         if (ls && c3n) begin
            disp = cap; dvalid = seen; seen = 1; wi = 0; k = 0;
         end
         if (c3n) begin
            cap[wi] = w; last_wr = w;
            if (wi < LP-1) wi++;
         end
         exp_sel = !f0n;
      end
      gcyc++;
   endtask

   // n c3 periods of one TV line; mode 1 = ramp, else random bytes.
   task automatic drive_line(input int n, input int mode, input bit start,
                             input int rst_at, input string tag);
      logic [8:0] w;
      int c;
      for (int i = 0; i < n; i++) begin
         w = (mode == 1) ? {1'b0, 8'(i)} : 9'($urandom);
         for (int p = 0; p < 4; p++) begin
            cycle(start && i == 0 && p == 0, i == rst_at && p == 0, w);
            c = 4*i + p;
            checks++;
            if ({vgaplex, vga_blank, vga_line, vga_hs, plex_sel} !== {exp_v, exp_sel}) begin
               errors++;
               $display("FAIL %s c=%0d got pix=%h blank=%b line=%b hs=%b sel=%b want pix=%h blank=%b line=%b hs=%b sel=%b",
                        tag, c, vgaplex, vga_blank, vga_line, vga_hs, plex_sel,
                        exp_v[10:3], exp_v[2], exp_v[1], exp_v[0], exp_sel);
            end
            if (vga_hs === 1'b1) hs_cnt++;
            if (vga_blank === 1'b0) vis_cnt++;
            if (exp_v[2] == 1'b0) exp_vis++;
            if (c == 897) obs447 = {vga_blank, vgaplex};
            if (i == rst_at && p == 0)
               rst_obs = {vgaplex, vga_blank, vga_line, vga_hs, plex_sel};
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 9'h000);
      checks++;
      if ({vgaplex, vga_blank, vga_line, vga_hs, plex_sel} !== {8'h00, 4'b1000}) begin
         errors++;
         $display("FAIL reset_values got %h want %h",
                  {vgaplex, vga_blank, vga_line, vga_hs, plex_sel}, {8'h00, 4'b1000});
      end
      drive_line(60, 0, 1'b0, -1, "pre_start");
   endtask

   task automatic test_first_start();
      vis_cnt = 0;
      drive_line(LP, 1, 1'b1, -1, "first_start");
      checks++;
      if (vis_cnt != 0) begin
         errors++;
         $display("FAIL first_start_blank visible_clks=%0d want 0", vis_cnt);
      end
   endtask

   task automatic test_ramp();
      hs_cnt = 0;
      drive_line(LP, 0, 1'b1, -1, "ramp");
      checks++;
      if (hs_cnt != 2*2*HS) begin
         errors++;
         $display("FAIL hsync_width hs_clks=%0d want %0d", hs_cnt, 2*2*HS);
      end
   endtask

   task automatic test_long_line();
      logic [8:0] b600;
      drive_line(600, 0, 1'b1, -1, "long_line");
      b600 = last_wr;
      checks++;
      if ({vga_blank, vgaplex, vga_line} !== {1'b1, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL long_hold got blank=%b pix=%h line=%b want blank=1 pix=00 line=1",
                  vga_blank, vgaplex, vga_line);
      end
      drive_line(LP, 0, 1'b1, -1, "after_long");
      checks++;
      if (obs447 !== b600) begin
         errors++;
         $display("FAIL slot447 got %h want %h", obs447, b600);
      end
   endtask

   task automatic test_hires();
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 1'b0, 9'($urandom));
         checks++;
         if (plex_sel !== (f0 ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL hires i=%0d f0=%b got sel=%b want %b", i, f0, plex_sel, !f0);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int l = 0; l < 3; l++)
         drive_line(LP + int'($urandom_range(0, 20)), 0, 1'b1, -1, "back_to_back");
   endtask

   task automatic test_reset_mid();
      drive_line(200, 0, 1'b1, 100, "reset_mid");
      checks++;
      if (rst_obs !== {8'h00, 4'b1000}) begin
         errors++;
         $display("FAIL reset_mid_values got %h want %h", rst_obs, {8'h00, 4'b1000});
      end
      vis_cnt = 0;
      drive_line(LP, 0, 1'b1, -1, "post_reset_1st");
      checks++;
      if (vis_cnt != 0) begin
         errors++;
         $display("FAIL post_reset_blank visible_clks=%0d want 0", vis_cnt);
      end
      vis_cnt = 0; exp_vis = 0;
      drive_line(LP, 0, 1'b1, -1, "post_reset_2nd");
      checks++;
      if (vis_cnt != exp_vis || exp_vis == 0) begin
         errors++;
         $display("FAIL post_reset_visible visible_clks=%0d want %0d", vis_cnt, exp_vis);
      end
   endtask

   initial begin
      rst = 1'b1; c3 = 1'b0; f0 = 1'b0; tv_line_start = 1'b0;
      tv_blank = 1'b0; vplex_in = 8'h00;
      test_reset();
      test_first_start();
      test_ramp();
      test_long_line();
      test_hires();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
